// File: rtl/event_led_scheduler.sv
// Round-robin sharing of one activity LED between NUM_SOURCES pulse sources.
// Each grant lights the LED for ON_TICKS cycles followed by GAP_TICKS dark cycles.
module event_led_scheduler #(
  parameter int CLK_FREQUENCY = 100000000,
  parameter int NUM_SOURCES   = 4,
  parameter int ON_MS         = 50,
  parameter int GAP_MS        = 10,
  localparam int SW = (NUM_SOURCES > 2) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_a,
  input  logic [NUM_SOURCES-1:0] pulse,
  input  logic                   enable,
  input  logic                   clearOverrun,
  output logic                   ledOn,
  output logic [SW-1:0]          activeSource,
  output logic [NUM_SOURCES-1:0] pending,
  output logic [NUM_SOURCES-1:0] overrun
);

  localparam int ON_TICKS  = $rtoi(CLK_FREQUENCY / 1.0e3 * ON_MS);
  localparam int GAP_TICKS = $rtoi(CLK_FREQUENCY / 1.0e3 * GAP_MS);
  localparam int MAX_T0    = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int MAX_T     = (MAX_T0 > 2) ? MAX_T0 : 2;
  localparam int CW        = $clog2(MAX_T);
  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_TICKS - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [SW-1:0]            last_grant;
  logic [SW-1:0]            win;
  logic                     found;
  logic                     arb_pt;
  logic                     grant;
  logic [NUM_SOURCES-1:0]   gmask;
  logic [NUM_SOURCES-1:0]   pend_nxt;
  logic [NUM_SOURCES-1:0]   ovr_nxt;

  // Rotating priority: search starts just after the previous winner.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int j = 1; j <= NUM_SOURCES; j++) begin
      if (!found && pending[(int'(last_grant) + j) % NUM_SOURCES]) begin
        found = 1'b1;
        win   = SW'((int'(last_grant) + j) % NUM_SOURCES);
      end
    end
  end

  always_comb begin
    arb_pt = (state == S_IDLE) ||
             (state == S_GAP && cnt == '0) ||
             (state == S_ON && cnt == '0 && GAP_TICKS == 0);
    grant  = arb_pt && enable && found;
    gmask  = grant ? (NUM_SOURCES'(1) << win) : '0;
    // A fresh pulse on the source being granted re-arms it instead of flagging overrun.
    pend_nxt = pulse | (pending & ~gmask);
    ovr_nxt  = (pulse & pending & ~gmask) | (overrun & ~{NUM_SOURCES{clearOverrun}});
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ledOn        <= 1'b0;
      activeSource <= '0;
      last_grant   <= SW'(NUM_SOURCES - 1);
      pending      <= '0;
      overrun      <= '0;
    end else begin
      pending <= pend_nxt;
      overrun <= ovr_nxt;
      if (grant) begin
        state        <= S_ON;
        cnt          <= ON_LOAD;
        ledOn        <= 1'b1;
        last_grant   <= win;
        activeSource <= win;
      end else begin
        case (state)
          S_ON: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else if (GAP_TICKS > 0) begin
              state <= S_GAP;
              cnt   <= GAP_LOAD;
              ledOn <= 1'b0;
            end else begin
              state <= S_IDLE;
              ledOn <= 1'b0;
            end
          end
          S_GAP: begin
            if (cnt != '0) cnt <= cnt - CW'(1);
            else           state <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
